// File: rtl/sfr_ext_pkg.sv
// Shared register map, control/status bit positions and byte-lane helper
// for the per-core SFR block.
package sfr_ext_pkg;

    localparam logic [31:0] OFF_CORENUM  = 32'h00;
    localparam logic [31:0] OFF_NUMCORES = 32'h04;
    localparam logic [31:0] OFF_CYCLE_LO = 32'h08;
    localparam logic [31:0] OFF_CYCLE_HI = 32'h0C;
    localparam logic [31:0] OFF_CTRL     = 32'h10;
    localparam logic [31:0] OFF_TCMP     = 32'h14;
    localparam logic [31:0] OFF_TCNT     = 32'h18;
    localparam logic [31:0] OFF_STATUS   = 32'h1C;
    localparam logic [31:0] OFF_SWI      = 32'h20;
    localparam logic [31:0] SCRATCH_BASE = 32'h40;

    localparam int CTRL_TEN = 0;
    localparam int CTRL_TIE = 1;
    localparam int CTRL_ARL = 2;
    localparam int CTRL_SIE = 3;

    localparam int ST_TIF = 0;
    localparam int ST_SIF = 1;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sfr_timer.sv
// 32-bit compare timer: free-running count with optional auto-reload on match;
// a bus write to the count wins over the hardware update in the same cycle.
module sfr_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ten,
    input  logic        arl,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        cnt_we,
    input  logic [31:0] cnt_wdata,
    output logic [31:0] tcmp,
    output logic [31:0] tcnt,
    output logic        tif_set
);

    logic match;

    // Compare always sees the count as it stood before any same-cycle write.
    assign match   = (tcnt == tcmp);
    assign tif_set = ten & match;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcmp <= '0;
            tcnt <= '0;
        end else begin
            if (cmp_we) tcmp <= cmp_wdata;
            if (cnt_we)
                tcnt <= cnt_wdata;
            else if (ten)
                tcnt <= (match && arl) ? '0 : tcnt + 32'd1;
        end
    end

endmodule

// File: rtl/sfr_ext.sv
// Per-core SFR block: ID registers, 64-bit cycle counter with coherent high
// read, compare timer, soft interrupt and a scratch bank on a zero-wait bus.
module sfr_ext
    import sfr_ext_pkg::*;
#(
    parameter int CORENUM     = 0,
    parameter int NUM_CORES   = 1,
    parameter int NUM_SCRATCH = 4,
    parameter int ADDR_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic        bus_resp,
    output logic [31:0] bus_rdata,
    output logic        irq_o
);

    // Keep only the decoded address bits, with the byte-lane bits cleared.
    localparam logic [63:0] AMASK_W     = (64'd1 << ADDR_W) - 64'd1;
    localparam logic [31:0] AMASK       = AMASK_W[31:0] & 32'hFFFF_FFFC;
    localparam logic [31:0] SCRATCH_END = SCRATCH_BASE + 32'(4 * NUM_SCRATCH);

    logic [31:0] off;
    logic        wr, rd, scr_hit;
    logic [3:0]  scr_idx;

    logic [63:0] cycle;
    logic [31:0] cycle_hi_shadow;
    logic [3:0]  ctrl;
    logic [1:0]  status, status_next;
    logic [31:0] scratch [NUM_SCRATCH];
    logic [31:0] rd_val;

    logic        cmp_we, cnt_we, tif_set;
    logic [31:0] tcmp, tcnt;

    assign bus_ack = bus_req;
    assign off     = bus_addr & AMASK;
    assign wr      = bus_req & bus_we;
    assign rd      = bus_req & ~bus_we;
    assign scr_hit = (off >= SCRATCH_BASE) && (off < SCRATCH_END);
    assign scr_idx = off[5:2];

    // A zero byte-enable must not count as a write, or it would stall the timer.
    assign cmp_we = wr && (off == OFF_TCMP) && (bus_be != 4'b0000);
    assign cnt_we = wr && (off == OFF_TCNT) && (bus_be != 4'b0000);

    sfr_timer u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ten       (ctrl[CTRL_TEN]),
        .arl       (ctrl[CTRL_ARL]),
        .cmp_we    (cmp_we),
        .cmp_wdata (be_merge(tcmp, bus_wdata, bus_be)),
        .cnt_we    (cnt_we),
        .cnt_wdata (be_merge(tcnt, bus_wdata, bus_be)),
        .tcmp      (tcmp),
        .tcnt      (tcnt),
        .tif_set   (tif_set)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CORENUM:  rd_val = 32'(CORENUM);
            OFF_NUMCORES: rd_val = 32'(NUM_CORES);
            OFF_CYCLE_LO: rd_val = cycle[31:0];
            OFF_CYCLE_HI: rd_val = cycle_hi_shadow;
            OFF_CTRL:     rd_val = {28'd0, ctrl};
            OFF_TCMP:     rd_val = tcmp;
            OFF_TCNT:     rd_val = tcnt;
            OFF_STATUS:   rd_val = {30'd0, status};
            default:      rd_val = '0;
        endcase
        if (scr_hit) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (scr_idx == 4'(i)) rd_val = scratch[i];
            end
        end
    end

    // Hardware sets are applied after the W1C so a colliding set wins.
    always_comb begin
        status_next = status;
        if (wr && (off == OFF_STATUS) && bus_be[0])
            status_next = status & ~bus_wdata[1:0];
        if (tif_set)
            status_next[ST_TIF] = 1'b1;
        if (wr && (off == OFF_SWI) && bus_be[0] && bus_wdata[0])
            status_next[ST_SIF] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle           <= '0;
            cycle_hi_shadow <= '0;
            ctrl            <= '0;
            status          <= '0;
            irq_o           <= 1'b0;
            bus_resp        <= 1'b0;
            bus_rdata       <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            cycle    <= cycle + 64'd1;
            status   <= status_next;
            irq_o    <= (status[ST_TIF] & ctrl[CTRL_TIE]) | (status[ST_SIF] & ctrl[CTRL_SIE]);
            bus_resp <= rd;
            if (rd) begin
                bus_rdata <= rd_val;
                if (off == OFF_CYCLE_LO) cycle_hi_shadow <= cycle[63:32];
            end
            if (wr && (off == OFF_CTRL) && bus_be[0])
                ctrl <= bus_wdata[3:0];
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr && scr_hit && (scr_idx == 4'(i)))
                    scratch[i] <= be_merge(scratch[i], bus_wdata, bus_be);
            end
        end
    end

endmodule

// File: tb/tb_sfr_ext.sv
// Randomised scoreboard bench for sfr_ext against a register-level reference model.
module tb_sfr_ext;

    localparam int NSCR = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_resp, irq_o;
    logic [31:0] bus_rdata;

    always #5 clk_i = ~clk_i;

    sfr_ext #(.CORENUM(3), .NUM_CORES(4), .NUM_SCRATCH(NSCR), .ADDR_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_resp(bus_resp), .bus_rdata(bus_rdata), .irq_o(irq_o)
    );

    typedef struct { logic [31:0] val; int tag; } exp_t;
    exp_t sb_q[$];
    int n_vec = 0, n_err = 0, neg_n = 0;

    // Reference state: what a programmer would believe the registers hold.
    logic [63:0] m_cyc;
    logic [31:0] m_shadow, m_tcmp, m_tcnt;
    logic [3:0]  m_ctrl;
    logic        m_tif, m_sif, m_irq;
    logic [31:0] m_scr [NSCR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_cyc = '0; m_shadow = '0; m_tcmp = '0; m_tcnt = '0; m_ctrl = '0;
        m_tif = 1'b0; m_sif = 1'b0; m_irq = 1'b0;
        for (int i = 0; i < NSCR; i++) m_scr[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int o;
        o = int'(addr[7:0]) & 'hFC;
        case (o)
            'h00: return 32'd3;
            'h04: return 32'd4;
            'h08: return m_cyc[31:0];
            'h0C: return m_shadow;
            'h10: return {28'd0, m_ctrl};
            'h14: return m_tcmp;
            'h18: return m_tcnt;
            'h1C: return {30'd0, m_sif, m_tif};
            default: begin
                if (o >= 'h40 && o < 'h40 + 4*NSCR) return m_scr[(o - 'h40) / 4];
                return 32'd0;
            end
        endcase
    endfunction

    // One clock edge of architectural behaviour.
    task automatic model_step(input logic req, input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
        int o;
        logic hit, tif_n, sif_n, irq_n;
        logic [31:0] cnt_n, cmp_n;
        logic [3:0] ctrl_n;
        o      = int'(addr[7:0]) & 'hFC;
        irq_n  = (m_tif && m_ctrl[1]) || (m_sif && m_ctrl[3]);
        hit    = m_ctrl[0] && (m_tcnt == m_tcmp);
        cnt_n  = !m_ctrl[0] ? m_tcnt : ((hit && m_ctrl[2]) ? 32'd0 : m_tcnt + 32'd1);
        cmp_n  = m_tcmp;
        ctrl_n = m_ctrl;
        tif_n  = m_tif;
        sif_n  = m_sif;
        if (req && we) begin
            case (o)
                'h10: if (be[0]) ctrl_n = wd[3:0];
                'h14: cmp_n = merge(m_tcmp, wd, be);
                'h18: if (be != 0) cnt_n = merge(m_tcnt, wd, be);
                'h1C: if (be[0]) begin
                          if (wd[0]) tif_n = 1'b0;
                          if (wd[1]) sif_n = 1'b0;
                      end
                'h20: if (be[0] && wd[0]) sif_n = 1'b1;
                default: if (o >= 'h40 && o < 'h40 + 4*NSCR)
                             m_scr[(o - 'h40) / 4] = merge(m_scr[(o - 'h40) / 4], wd, be);
            endcase
        end
        if (hit) tif_n = 1'b1;
        if (req && !we && o == 'h08) m_shadow = m_cyc[63:32];
        m_cyc  = m_cyc + 64'd1;
        m_tcnt = cnt_n; m_tcmp = cmp_n; m_ctrl = ctrl_n;
        m_tif  = tif_n; m_sif = sif_n; m_irq = irq_n;
    endtask

    // Called at posedge+1; drives one bus cycle and returns at the next posedge+1.
    task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input bit push = 1'b1);
        exp_t e;
        check("irq_o", 32'(irq_o), 32'(m_irq));
        bus_req = req; bus_we = we; bus_addr = addr; bus_be = be; bus_wdata = wd;
        #1 check("bus_ack", 32'(bus_ack), 32'(req));
        if (req && !we && push) begin
            e.val = model_read(addr);
            e.tag = neg_n + 2;
            sb_q.push_back(e);
        end
        model_step(req, we, addr, be, wd);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        cyc(1'b1, 1'b1, a, be, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 4'hF, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    endtask

    // Monitor: pops one expectation per response and checks its data and timing.
    always @(negedge clk_i) begin
        neg_n++;
        if (bus_resp === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'(bus_resp), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rdata", bus_rdata, e.val);
                check("resp_cycle", 32'(neg_n), 32'(e.tag));
            end
        end else if (sb_q.size() != 0 && sb_q[0].tag <= neg_n) begin
            void'(sb_q.pop_front());
            check("missing_resp", 32'(bus_resp), 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int offs[18] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20,
                         'h24, 'h3C, 'h40, 'h44, 'h48, 'h4C, 'h50, 'h7C, 'hFC};
        rst_i = 1'b1;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("reset_resp", 32'(bus_resp), 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", 32'(irq_o), 32'd0);

        // ID registers, back to back
        rd(32'h00); rd(32'h04);

        // cycle counter pair
        idle(100);
        rd(32'h08); rd(32'h0C); idle(5); rd(32'hABCD_0E08); rd(32'h0C);

        // compare timer with auto-reload and W1C collisions
        wr(32'h14, 32'd5); wr(32'h18, 32'd0); wr(32'h10, 32'h7);
        idle(8);
        for (int i = 0; i < 12; i++) wr(32'h1C, 32'h1);
        for (int i = 0; i < 12; i++) if (i % 2 == 0) rd(32'h1C); else rd(32'h18);
        wr(32'h10, 32'h0); wr(32'h1C, 32'h3); idle(2); rd(32'h1C);

        // scratch byte enables and out-of-range
        wr(32'h48, 32'hFFFF_FFFF); wr(32'h48, 32'h1234_5678, 4'b0101); rd(32'h48);
        rd(32'h40 + 4*NSCR); wr(32'h50, 32'hDEAD_BEEF); rd(32'h50);

        // soft interrupt
        wr(32'h10, 32'h8); wr(32'h20, 32'h1, 4'b1110); idle(2); rd(32'h1C);
        wr(32'h20, 32'h1); idle(2); rd(32'h1C);

        // async reset right after a read is accepted
        cyc(1'b1, 1'b0, 32'h00, 4'hF, 32'd0, 1'b0);
        check("pre_rst_resp", 32'(bus_resp), 32'd1);
        #1 rst_i = 1'b1;
        bus_req = 1'b0; bus_we = 1'b0;
        #1;
        check("rst_resp_async", 32'(bus_resp), 32'd0);
        check("rst_irq_async", 32'(irq_o), 32'd0);
        check("rst_rdata_async", bus_rdata, 32'd0);
        @(posedge clk_i); @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        idle(3);
        rd(32'h1C); rd(32'h10);

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            logic [3:0] be;
            int o;
            o = offs[$urandom_range(0, 17)];
            a = $urandom();
            a[7:0] = 8'(o) | 8'($urandom_range(0, 3));
            be = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
            if (o == 'h14 || o == 'h18)
                d = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 12) : $urandom();
            else if (o == 'h10)
                d = $urandom_range(0, 15);
            else if (o == 'h1C || o == 'h20)
                d = $urandom_range(0, 3);
            else
                d = $urandom();
            if ($urandom_range(0, 9) < 3)
                idle(1);
            else
                cyc(1'b1, 1'($urandom_range(0, 1)), a, be, d);
        end

        idle(4);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sfr_ext.md
Name: sfr_ext

Overview:
Per-core special-function-register block on the core's data bus, second generation of the core-ID SFR. Provides:
- core ID and core count
- 64-bit cycle counter with coherent high-word read
- 32-bit compare timer with interrupt
- software-interrupt bit
- a parametrised bank of scratch registers

Sits beside each core's data port in the multicore fabric; `irq_o` feeds the core's interrupt input.

Parameters:
CORENUM, 0, value returned by the CORENUM register
NUM_CORES, 1, value returned by the NUMCORES register
NUM_SCRATCH, 4, number of 32-bit scratch registers, legal range 1..16
ADDR_W, 8, number of low address bits decoded; bus_addr[31:ADDR_W] ignored; minimum 7

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
bus_req  in  1  access request
bus_we  in  1  1 = write, 0 = read
bus_addr  in  32  byte address; bits [1:0] ignored
bus_be  in  4  byte enables for writes
bus_wdata  in  32  write data
bus_ack  out  1  request accepted (combinational, equals bus_req)
bus_resp  out  1  read data valid, registered
bus_rdata  out  32  read data, registered
irq_o  out  1  interrupt, registered

Behaviour:
- Reset (async, rst_i=1): bus_resp=0, bus_rdata=0, irq_o=0; all counters, CTRL, CMP, status, and scratch registers reset to 0; the CYCLE_HI shadow resets to 0. Reset mid-transaction drops any pending response.
- Handshake:
  - Every request is accepted in the cycle it is presented; there are no wait states.
  - Read: bus_resp=1 exactly one cycle after acceptance, with bus_rdata valid in that cycle. Back-to-back reads give back-to-back responses.
  - Write: takes effect at the accepting clock edge and produces no response.
  - bus_rdata holds its last value when bus_resp=0.
- Register map (word offsets on bus_addr[ADDR_W-1:0]):
  - 0x00 CORENUM (RO) = CORENUM.
  - 0x04 NUMCORES (RO) = NUM_CORES.
  - 0x08 CYCLE_LO (RO): a read returns cycle[31:0] and, in the same edge, latches cycle[63:32] into the HI shadow.
  - 0x0C CYCLE_HI (RO): returns the shadow.
  - 0x10 CTRL (RW): bit0 TEN timer enable, bit1 TIE timer-irq enable, bit2 ARL auto-reload, bit3 SIE soft-irq enable; other bits read 0.
  - 0x14 TCMP (RW), 0x18 TCNT (RW).
  - 0x1C STATUS (W1C): bit0 TIF, bit1 SIF.
  - 0x20 SWI (WO): writing bit0=1 sets SIF; reads 0.
  - 0x40+4*i SCRATCH[i] (RW), i < NUM_SCRATCH.
  - Any other offset: reads 0, writes ignored.
- Byte enables:
  - RW registers update only the enabled bytes.
  - W1C on STATUS and the SWI write act only when byte 0 is enabled.
  - A write with bus_be=0 has no effect.
- Cycle counter: 64-bit, increments every cycle after reset, wraps 2^64-1 to 0, not writable.
- Timer, with TEN=1, each cycle:
  - If TCNT==TCMP: set TIF. Next TCNT = 0 if ARL=1, else TCNT+1.
  - Otherwise TCNT = TCNT+1. Wraps at 2^32.
  - With TEN=0, TCNT holds.
- Timer collisions:
  - A bus write to TCNT in the same cycle overrides the increment/reload.
  - The compare uses the pre-write TCNT value.
- Status collisions: a hardware set of TIF/SIF in the same cycle as a W1C of the same bit leaves the bit set (set wins).
- irq_o is registered: irq_o <= (TIF & TIE) | (SIF & SIE). Latency from the flag setting to irq_o=1 is one cycle; clearing behaves the same.
- A read of a register in the same cycle as a write to it is not possible, since there is a single request per cycle.

Decomposition:
- Package sfr_ext_pkg holds:
  - register offset localparams (CORENUM..SWI, SCRATCH_BASE=0x40)
  - CTRL bit indices (TEN=0, TIE=1, ARL=2, SIE=3)
  - STATUS bit indices (TIF=0, SIF=1)
- Sub-module sfr_timer: TCNT/TCMP compare, increment/reload, write override, TIF set pulse. The top level keeps decode, byte-enable merging, the cycle counter, status/irq logic, and the scratch bank.

Test Plan:
- Reset, then read 0x00 and 0x04 with CORENUM=3, NUM_CORES=4 -> bus_resp one cycle after each request, rdata=3 then 4; bus_ack equals bus_req in the same cycle.
- Reset run ~100 cycles, read CYCLE_LO, then CYCLE_HI -> HI equals the shadow latched at the LO read. Force a carry case (cycle[31:0] near 0xFFFFFFFF) -> HI/LO pair is consistent.
- TCMP=5, TCNT=0, CTRL=0b0111 -> TIF set when TCNT==5, TCNT reloads to 0, irq_o=1 one cycle later. Write STATUS=1 -> TIF clears and irq_o drops one cycle later. W1C in the same cycle as the next match -> TIF remains 1.
- Write SCRATCH[2]=0xFFFFFFFF, then write 0x12345678 with be=0b0101, then read -> 0xFF34FF78. Read offset 0x40+4*NUM_SCRATCH -> 0.
- CTRL.SIE=1, write SWI=1 -> SIF=1 and irq_o=1 next cycle. Write SWI with be=0b1110 -> no effect.
- Assert rst_i asynchronously one cycle after a read request -> bus_resp=0 and irq_o=0 immediately; no response emitted after rst_i deasserts.
